// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster counter / video_on generator for the VGA path, plus the
// arbiter for the single port of the shared pixel RAM. Display fetch has fixed
// priority; a host writer gets the port through a four-phase req/ack handshake
// and only in clocks that carry no display read.
module vga_scan_ctrl #(
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int AW       = 19,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [9:0]    CounterX,
    output logic [9:0]    CounterY,
    output logic          video_on,
    output logic          frame_start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          rd_valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack
);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ON   = 10'(H_START);
    localparam logic [9:0] X_OFF  = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] Y_ON   = 10'(V_START);
    localparam logic [9:0] Y_OFF  = 10'(V_START + V_ACTIVE);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    logic [9:0]    cnt_x_r;
    logic [9:0]    cnt_y_r;
    logic          frame_start_r;
    logic          rd_valid_r;
    logic          wr_ack_r;
    logic [AW-1:0] rd_ptr_r;
    state_t        state_r;
    state_t        state_nxt_s;

    logic          x_end_s;
    logic          y_end_s;
    logic          wrap_s;
    logic          video_on_s;
    logic          disp_slot_s;
    logic [AW-1:0] mem_addr_s;
    logic          mem_we_s;

    // Raster decode: end-of-line/frame detection, active window, display slot.
    always_comb begin
        x_end_s     = (cnt_x_r == X_LAST);
        y_end_s     = (cnt_y_r == Y_LAST);
        wrap_s      = pix_en & x_end_s & y_end_s;
        video_on_s  = (cnt_x_r >= X_ON) && (cnt_x_r < X_OFF) &&
                      (cnt_y_r >= Y_ON) && (cnt_y_r < Y_OFF);
        disp_slot_s = pix_en & video_on_s;
    end

    // Raster counters: X advances per pixel strobe, Y advances on each line wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x_r <= 10'd0;
            cnt_y_r <= 10'd0;
        end else if (pix_en) begin
            if (x_end_s) begin
                cnt_x_r <= 10'd0;
                if (y_end_s) begin
                    cnt_y_r <= 10'd0;
                end else begin
                    cnt_y_r <= cnt_y_r + 10'd1;
                end
            end else begin
                cnt_x_r <= cnt_x_r + 10'd1;
            end
        end else begin
            cnt_x_r <= cnt_x_r;
            cnt_y_r <= cnt_y_r;
        end
    end

    // Frame pulse and read-valid flag, both one clock behind their cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r <= 1'b0;
            rd_valid_r    <= 1'b0;
        end else begin
            frame_start_r <= wrap_s;
            rd_valid_r    <= disp_slot_s;
        end
    end

    // Display read pointer: row-major over the active area, rewinds only at frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
        end else if (wrap_s) begin
            rd_ptr_r <= {AW{1'b0}};
        end else if (disp_slot_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Writer FSM next state and RAM port mux; a display slot always owns the port.
    always_comb begin
        state_nxt_s = state_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = wr_addr;
        case (state_r)
            ST_IDLE: begin
                if (wr_req) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (disp_slot_s) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    mem_we_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!wr_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (disp_slot_s) begin
            mem_addr_s = rd_ptr_r;
        end else begin
            mem_addr_s = wr_addr;
        end
    end

    // Writer state register; ack is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            wr_ack_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            wr_ack_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign CounterX    = cnt_x_r;
    assign CounterY    = cnt_y_r;
    assign video_on    = video_on_s;
    assign frame_start = frame_start_r;
    assign mem_addr    = mem_addr_s;
    assign mem_we      = mem_we_s;
    assign mem_wdata   = wr_data;
    assign rd_valid    = rd_valid_r;
    assign wr_ack      = wr_ack_r;

endmodule
